product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of the 8-bit Dadda/array multiplier product stream (clk, a, b -> p[15:0]).
- Carries operand valid/last qualifiers through a delay line matched to the multiplier latency, so they line up with p.
- Accumulates products into groups delimited by a last flag, and presents each group sum, term count and saturation flag on a valid/ready output.
- Serves as the MAC back-end for dot-product tests and as a self-check sink for exhaustive multiplier sweeps.

Parameters:
- P_W, 16, product width; must match the multiplier output.
- ACC_W, 24, accumulator and result width; must be >= P_W.
- CNT_W, 8, term-counter width.
- MULT_LAT, 1, multiplier latency in clocks from a/b to p; must be >= 1.
- SATURATE, 1, selects overflow handling: 1 = clamp at all-ones, 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  the a/b presented to the multiplier this cycle are valid.
- op_last  in  1  the operand pair is the last of its group; ignored unless op_valid=1.
- p_in  in  P_W  multiplier product.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  group sum.
- out_cnt  out  CNT_W  number of terms in the group; saturates at 2^CNT_W-1.
- out_sat  out  1  the group sum saturated (SATURATE=1) or wrapped (SATURATE=0).
- overrun  out  1  sticky; a completed group was dropped.

Behaviour:
- Reset, asynchronous: clears the delay line, acc, cnt, sat and the result register. out_valid=0, out_sum=0, out_cnt=0, out_sat=0, overrun=0. Group state is set to FIRST.
- Reset mid-group: the partial group and any in-flight operands are discarded.
- Delay line: op_valid/op_last are shifted MULT_LAT stages, giving p_valid/p_last aligned with p_in. Bubbles propagate unchanged. There is no input backpressure; the multiplier free-runs.
- Group state machine: FIRST (acc empty) and ACCUM.
  - On p_valid: base = 0 in FIRST, otherwise acc. sum = base + zero-extended p_in, computed at ACC_W+1 bits.
    - Carry-out with SATURATE=1: acc = all-ones, sat = 1.
    - Carry-out with SATURATE=0: acc = low ACC_W bits, sat = 1.
    - sat is OR-accumulated across the group.
  - cnt = (FIRST ? 1 : cnt+1), saturating at the maximum value.
  - p_valid && !p_last: state goes to ACCUM.
  - p_valid && p_last: the finished sum/cnt/sat (including this term) complete the group; state returns to FIRST.
  - A cycle with p_valid=0 holds all state.
- Output register:
  - Completion with out_valid=0, or with out_valid=1 && out_ready=1: load the result and set out_valid=1. A simultaneous consume and load is legal and allows back-to-back single-term groups at full rate.
  - Completion with out_valid=1 && out_ready=0: the new result is dropped, the held result stays unchanged, and overrun is set to 1 until reset.
  - out_valid=1 && out_ready=1 with no completion: out_valid clears next cycle. out_sum/out_cnt/out_sat hold their last value.
  - out_* are stable while out_valid=1 && out_ready=0.
- Latency: op_last at edge t gives out_valid=1 after edge t+MULT_LAT+1.
- Width rule: products are always unsigned and zero-extended. Signed operation is out of scope.

Decomposition:
- Package prod_acc_pkg: P_W, ACC_W and CNT_W defaults; localparam ACC_MAX = all-ones; enum group_state_t {FIRST, ACCUM}.
- One sub-module, valid_delay_line: a parameterised-depth shift register of {valid, last} with async reset. It is reusable for any pipelined multiplier (array, Wallace, Dadda).

Test Plan:
- Single term: a=b=255 with op_valid=op_last=1 at t, out_ready=1 -> out_valid at t+2 (MULT_LAT=1), out_sum=65025, out_cnt=1, out_sat=0.
- Four-term group (1,1),(2,2),(3,3),(4,4), last on the 4th, with one bubble cycle mid-group -> out_sum=30, out_cnt=4. The bubble must not change the result.
- ACC_W=16: two terms of 255*255 -> SATURATE=1 gives out_sum=65535, out_sat=1; SATURATE=0 gives out_sum=64514, out_sat=1.
- Overrun: complete group A (sum 4), hold out_ready=0, complete group B (sum 9) -> out_sum stays 4, overrun=1. Then raise out_ready -> out_valid clears and overrun stays 1.
- Reset mid-group: after 2 of 3 terms (and one in flight), pulse rst -> all outputs are 0. A fresh single-term group 3*5 -> out_sum=15, out_cnt=1.
- Back-to-back: exhaustive {a,b}=i sweep, every op a 1-term group, out_ready=1 -> one result per cycle, each out_sum equals a*b, overrun stays 0.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared defaults and types for the multiplier-product accumulator.
package prod_acc_pkg;

    localparam int unsigned P_W_DEF   = 16;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

    typedef enum logic {
        FIRST,
        ACCUM
    } group_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register for {valid, last} qualifiers, matched to a pipelined multiplier's latency.
module valid_delay_line #(
    parameter int unsigned Depth = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [Depth-1:0] valid_q, valid_d;
    logic [Depth-1:0] last_q, last_d;

    always_comb begin
        valid_d    = valid_q;
        last_d     = last_q;
        valid_d[0] = valid_i;
        // last only has meaning alongside valid
        last_d[0]  = last_i & valid_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            valid_d[i] = valid_q[i-1];
            last_d[i]  = last_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign last_o  = last_q[Depth-1];

endmodule

// File: rtl/product_accumulator.sv
// Groups multiplier products by a last flag and presents sum, term count and overflow
// flag on a valid/ready result register.
module product_accumulator
    import prod_acc_pkg::*;
#(
    parameter int unsigned P_W      = P_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MULT_LAT = 1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic             op_last,
    input  logic [P_W-1:0]   p_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat,
    output logic             overrun
);

    localparam logic [ACC_W-1:0] AccMax = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic p_valid;
    logic p_last;

    valid_delay_line #(
        .Depth (MULT_LAT)
    ) u_delay (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (op_valid),
        .last_i  (op_last),
        .valid_o (p_valid),
        .last_o  (p_last)
    );

    group_state_t     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             done;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        done     = 1'b0;

        base     = (state_q == FIRST) ? '0 : acc_q;
        sum_wide = {1'b0, base} + (ACC_W+1)'(p_in);
        carry    = sum_wide[ACC_W];
        acc_next = (SATURATE && carry) ? AccMax : sum_wide[ACC_W-1:0];
        sat_next = ((state_q == FIRST) ? 1'b0 : sat_q) | carry;

        if (state_q == FIRST) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_q == CntMax) begin
            cnt_next = cnt_q;
        end else begin
            cnt_next = cnt_q + CNT_W'(1);
        end

        if (p_valid) begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            sat_d = sat_next;
            if (p_last) begin
                done    = 1'b1;
                state_d = FIRST;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FIRST;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_sat_q, out_sat_d;
    logic             overrun_q, overrun_d;
    logic             load;

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_sat_d   = out_sat_q;
        overrun_d   = overrun_q;

        // A consume and a load in the same cycle keeps single-term groups at full rate
        load = done && (!out_valid_q || out_ready);

        if (load) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_next;
            out_cnt_d   = cnt_next;
            out_sat_d   = sat_next;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (done && out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_sat_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_sat_q   <= out_sat_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_sat   = out_sat_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a default instance plus two 16-bit-accumulator instances (clamp, wrap).
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_last;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] p_in;
    logic        out_ready;

    always #5 clk = ~clk;

    // Behavioural one-cycle multiplier feeding all instances
    always @(posedge clk or posedge rst) begin
        if (rst) p_in <= '0;
        else     p_in <= 16'(a_r) * 16'(b_r);
    end

    logic        v24, s24, o24;
    logic [23:0] sum24;
    logic [7:0]  c24;
    logic        vs, ss, os;
    logic [15:0] sums;
    logic [7:0]  cs;
    logic        vw, sw, ow;
    logic [15:0] sumw;
    logic [7:0]  cw;

    product_accumulator u_dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .p_in      (p_in),
        .out_valid (v24),
        .out_ready (out_ready),
        .out_sum   (sum24),
        .out_cnt   (c24),
        .out_sat   (s24),
        .overrun   (o24)
    );

    product_accumulator #(
        .ACC_W    (16),
        .SATURATE (1'b1)
    ) u_sat16 (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .p_in      (p_in),
        .out_valid (vs),
        .out_ready (out_ready),
        .out_sum   (sums),
        .out_cnt   (cs),
        .out_sat   (ss),
        .overrun   (os)
    );

    product_accumulator #(
        .ACC_W    (16),
        .SATURATE (1'b0)
    ) u_wrap16 (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .p_in      (p_in),
        .out_valid (vw),
        .out_ready (out_ready),
        .out_sum   (sumw),
        .out_cnt   (cw),
        .out_sat   (sw),
        .overrun   (ow)
    );

    typedef struct {
        logic [23:0] sum;
        logic [7:0]  cnt;
        logic        sat;
        logic [15:0] s16;
        logic        sat16;
        logic [15:0] w16;
    } exp_t;

    exp_t   sb_q[$];
    longint g_tot;
    int     g_n;
    int     n_checks;
    int     n_pass;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic exp_t mk_exp(input longint tot, input int n);
        exp_t e;
        e.sum   = (tot > 64'hFF_FFFF) ? 24'hFF_FFFF : tot[23:0];
        e.sat   = (tot > 64'hFF_FFFF);
        e.cnt   = (n > 255) ? 8'hFF : n[7:0];
        e.s16   = (tot > 64'hFFFF) ? 16'hFFFF : tot[15:0];
        e.sat16 = (tot > 64'hFFFF);
        e.w16   = tot[15:0];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic last,
                      input logic push);
        a_r      = a;
        b_r      = b;
        op_valid = 1'b1;
        op_last  = last;
        g_tot    = g_tot + longint'(a) * longint'(b);
        g_n++;
        if (last) begin
            if (push) sb_q.push_back(mk_exp(g_tot, g_n));
            g_tot = 0;
            g_n   = 0;
        end
    endtask

    // Every accepted result is matched against the oldest expected group
    always @(negedge clk) begin
        if (!rst && v24 && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(sum24), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum24", 32'(sum24), 32'(e.sum));
                check("cnt24", 32'(c24), 32'(e.cnt));
                check("sat24", 32'(s24), 32'(e.sat));
                check("valid_sat16", 32'(vs), 32'd1);
                check("sum_sat16", 32'(sums), 32'(e.s16));
                check("flag_sat16", 32'(ss), 32'(e.sat16));
                check("valid_wrap16", 32'(vw), 32'd1);
                check("sum_wrap16", 32'(sumw), 32'(e.w16));
                check("flag_wrap16", 32'(sw), 32'(e.sat16));
                check("cnt_wrap16", 32'(cw), 32'(e.cnt));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(v24), 32'd0);
        check({tag, "_sum"}, 32'(sum24), 32'd0);
        check({tag, "_cnt"}, 32'(c24), 32'd0);
        check({tag, "_sat"}, 32'(s24), 32'd0);
        check({tag, "_overrun"}, 32'(o24), 32'd0);
        check({tag, "_overrun16"}, 32'(os | ow), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        g_tot     = 0;
        g_n       = 0;
        a_r       = '0;
        b_r       = '0;
        out_ready = 1'b1;
        idle();
        rst       = 1'b1;
        #12;
        check_zero("reset");
        rst = 1'b0;
        step();

        // Single term 255*255: result visible two edges after the operand is sampled
        op(8'd255, 8'd255, 1'b1, 1'b1);
        step();
        idle();
        @(negedge clk);
        check("latency_early", 32'(v24), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("latency_valid", 32'(v24), 32'd1);
        step();
        step();

        // Four terms with a bubble mid-group
        op(8'd1, 8'd1, 1'b0, 1'b1);
        step();
        op(8'd2, 8'd2, 1'b0, 1'b1);
        step();
        idle();
        step();
        op(8'd3, 8'd3, 1'b0, 1'b1);
        step();
        op(8'd4, 8'd4, 1'b1, 1'b1);
        step();
        idle();
        repeat (3) step();

        // Two 255*255 terms: overflow the 16-bit instances
        op(8'd255, 8'd255, 1'b0, 1'b1);
        step();
        op(8'd255, 8'd255, 1'b1, 1'b1);
        step();
        idle();
        repeat (3) step();

        // Overrun: group B completes while group A is held
        out_ready = 1'b0;
        op(8'd2, 8'd2, 1'b1, 1'b1);
        step();
        op(8'd3, 8'd3, 1'b1, 1'b0);
        step();
        idle();
        repeat (3) step();
        check("hold_valid", 32'(v24), 32'd1);
        check("hold_sum", 32'(sum24), 32'd4);
        check("hold_cnt", 32'(c24), 32'd1);
        check("overrun_set", 32'(o24), 32'd1);
        check("overrun_set16", 32'(os & ow), 32'd1);
        out_ready = 1'b1;
        step();
        step();
        check("drain_valid", 32'(v24), 32'd0);
        check("drain_sum_held", 32'(sum24), 32'd4);
        check("overrun_sticky", 32'(o24), 32'd1);

        // Reset with two terms accumulated and the third in flight
        op(8'd1, 8'd2, 1'b0, 1'b0);
        step();
        op(8'd2, 8'd2, 1'b0, 1'b0);
        step();
        op(8'd3, 8'd3, 1'b1, 1'b0);
        step();
        idle();
        rst = 1'b1;
        #2;
        check_zero("midreset");
        rst = 1'b0;
        step();
        repeat (2) step();
        check("post_reset_idle", 32'(v24), 32'd0);
        op(8'd3, 8'd5, 1'b1, 1'b1);
        step();
        idle();
        repeat (3) step();

        // Exhaustive sweep, each op its own group, full rate
        for (int i = 0; i < 65536; i++) begin
            op(i[15:8], i[7:0], 1'b1, 1'b1);
            step();
        end
        idle();
        step();
        step();
        check("sweep_drained", 32'(sb_q.size()), 32'd0);
        check("sweep_overrun", 32'(o24 | os | ow), 32'd0);
        step();
        check("sweep_idle", 32'(v24), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
